// File: rtl/data_mem_responder.sv
// Purpose : multi-cycle data RAM for the MEM stage; serves RISC-V loads/stores with byte/half/word sizing.
// Latency : response strobe `latency` cycles after acceptance; one request per latency+1 cycles.
// Backpr. : req_ready only in IDLE; stall = req_valid & ~resp_valid holds the pipeline until the response.
//
// Ports:
//   clk, reset          - single clock; synchronous active-low reset
//   req_valid/write     - request present (held until response cycle), 1 = store
//   req_addr            - byte address; [aw-1:2] word index, [1:0] byte lane
//   req_wdata           - store data (low byte/half used for SB/SH)
//   req_funct3          - RISC-V size/sign code
//   req_ready           - registered, high in IDLE only
//   resp_valid          - one-cycle response strobe
//   resp_rdata          - extended load data, 0 for stores/errors, held until next response
//   resp_err            - misaligned/illegal access, only meaningful with resp_valid
//   stall               - combinational pipeline hold
module data_mem_responder #(
   parameter int data_width    = 32,
   parameter int address_width = 12,
   parameter int latency       = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   input  logic                     req_write,
   input  logic [address_width-1:0] req_addr,
   input  logic [data_width-1:0]    req_wdata,
   input  logic [2:0]               req_funct3,
   output logic                     req_ready,
   output logic                     resp_valid,
   output logic [data_width-1:0]    resp_rdata,
   output logic                     resp_err,
   output logic                     stall
);

   localparam int         words      = 2 ** (address_width - 2);
   localparam logic [3:0] count_load = 4'(latency - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] count;

   // Request captured at acceptance; the pipeline is expected to hold its
   // fields, but the latched copy keeps the access well defined if it does not.
   logic                     lat_write;
   logic [address_width-1:0] lat_addr;
   logic [data_width-1:0]    lat_wdata;
   logic [2:0]               lat_funct3;

   logic [data_width-1:0] mem [0:words-1];

   // With latency 1 the RAM access happens on the accept edge itself, before
   // the latch has loaded, so the live request fields must be used there.
   logic                     cur_write;
   logic [address_width-1:0] cur_addr;
   logic [data_width-1:0]    cur_wdata;
   logic [2:0]               cur_funct3;

   always_comb begin
      if (state == IDLE) begin
         cur_write  = req_write;
         cur_addr   = req_addr;
         cur_wdata  = req_wdata;
         cur_funct3 = req_funct3;
      end else begin
         cur_write  = lat_write;
         cur_addr   = lat_addr;
         cur_wdata  = lat_wdata;
         cur_funct3 = lat_funct3;
      end
   end

   // Edge on which the FSM moves into RESP: RAM is read/written here.
   logic enter_resp;
   assign enter_resp = ((state == IDLE) && req_valid && (latency == 1)) ||
                       ((state == WAIT) && (count == 4'd1));

   logic [1:0]               lane;
   logic [address_width-3:0] word_idx;
   logic [data_width-1:0]    old_word;
   logic [7:0]               byte_sel;
   logic [15:0]              half_sel;

   assign lane     = cur_addr[1:0];
   assign word_idx = cur_addr[address_width-1:2];
   assign old_word = mem[word_idx];
   assign byte_sel = old_word[{lane, 3'b000} +: 8];
   assign half_sel = old_word[{lane[1], 4'b0000} +: 16];

   // Access decode: error flag, extended load value, merged store word.
   logic                  acc_err;
   logic [data_width-1:0] load_data;
   logic [data_width-1:0] new_word;
   logic                  do_write;

   always_comb begin
      acc_err   = 1'b0;
      load_data = '0;
      new_word  = old_word;
      if (cur_write) begin
         case (cur_funct3)
            3'b000: new_word[{lane, 3'b000} +: 8] = cur_wdata[7:0];
            3'b001: begin
               if (lane[0]) acc_err = 1'b1;
               new_word[{lane[1], 4'b0000} +: 16] = cur_wdata[15:0];
            end
            3'b010: begin
               if (lane != 2'b00) acc_err = 1'b1;
               new_word = cur_wdata;
            end
            default: acc_err = 1'b1;
         endcase
      end else begin
         case (cur_funct3)
            3'b000: load_data = {{(data_width-8){byte_sel[7]}}, byte_sel};
            3'b100: load_data = {{(data_width-8){1'b0}}, byte_sel};
            3'b001: begin
               if (lane[0]) acc_err = 1'b1;
               load_data = {{(data_width-16){half_sel[15]}}, half_sel};
            end
            3'b101: begin
               if (lane[0]) acc_err = 1'b1;
               load_data = {{(data_width-16){1'b0}}, half_sel};
            end
            3'b010: begin
               if (lane != 2'b00) acc_err = 1'b1;
               load_data = old_word;
            end
            default: acc_err = 1'b1;
         endcase
      end
      do_write = cur_write & ~acc_err;
   end

   // Control FSM with registered handshake/response outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         count      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write  <= req_write;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  lat_funct3 <= req_funct3;
                  count      <= count_load;
                  req_ready  <= 1'b0;
                  state      <= (latency == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) state <= RESP;
            end
            RESP: begin
               // A request presented during RESP is not taken here; it is
               // picked up in the following IDLE cycle.
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
            end
         endcase

         if (enter_resp) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || cur_write) ? '0 : load_data;
         end
      end
   end

   // RAM contents survive reset; a reset on the commit edge suppresses the store.
   always_ff @(posedge clk) begin
      if (reset && enter_resp && do_write) mem[word_idx] <= new_word;
   end

   assign stall = req_valid & ~resp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : directed check of data_mem_responder at latency 2 (main table), 1 and 4 (sweep, reset abort).
// Latency : drives at negedge, samples at negedge, response counted in cycles after acceptance.
// Backpr. : each request held until its response strobe, next request issued the following IDLE cycle.
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       rst_n;
   logic [2:0]       req_valid, req_write, req_ready, resp_valid, resp_err, stall;
   logic [2:0][11:0] req_addr;
   logic [2:0][31:0] req_wdata, resp_rdata;
   logic [2:0][2:0]  req_funct3;

   // Instance 0: latency 2, instance 1: latency 1, instance 2: latency 4.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .data_width   (32),
         .address_width(12),
         .latency      (g == 0 ? 2 : (g == 1 ? 1 : 4))
      ) dut (
         .clk       (clk),
         .reset     (rst_n[g]),
         .req_valid (req_valid[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_funct3(req_funct3[g]),
         .req_ready (req_ready[g]),
         .resp_valid(resp_valid[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_err  (resp_err[g]),
         .stall     (stall[g])
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
   endfunction

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, id, act, exp);
      end
   endtask

   // Issue one request on instance k, hold it until the response, check timing and data.
   task automatic run_req(input int k, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input logic [31:0] exp_d, input logic exp_e, input int id);
      int cyc;
      int stl;
      bit got;
      @(negedge clk);
      req_valid[k]  = 1'b1;
      req_write[k]  = wr;
      req_addr[k]   = a;
      req_wdata[k]  = wd;
      req_funct3[k] = f3;
      #1;
      check("ready_at_issue", id, 32'(req_ready[k]), 32'd1);
      check("err_idle", id, 32'(resp_err[k]), 32'd0);
      cyc = 0;
      stl = stall[k] ? 1 : 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         check("ready_resp_overlap", id, 32'(req_ready[k] & resp_valid[k]), 32'd0);
         if (resp_valid[k]) got = 1'b1;
         else if (stall[k]) stl++;
      end
      check("resp_latency", id, cyc, lat_of(k));
      check("stall_cycles", id, stl, lat_of(k));
      check("stall_at_resp", id, 32'(stall[k]), 32'd0);
      check("rdata", id, resp_rdata[k], exp_d);
      check("err", id, 32'(resp_err[k]), 32'(exp_e));
      req_valid[k] = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [2:0]  f3;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_resp;

      // Latency-2 table: {wr, addr, wdata, funct3, expected rdata, expected err}
      tbl.push_back('{1'b1, 12'h010, 32'hDEADBEEF, 3'b010, 32'h0000_0000, 1'b0}); // SW
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0}); // LW
      tbl.push_back('{1'b0, 12'h013, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0}); // LB
      tbl.push_back('{1'b0, 12'h013, 32'h0,        3'b100, 32'h000000DE, 1'b0}); // LBU
      tbl.push_back('{1'b0, 12'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0}); // LH
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b101, 32'h0000BEEF, 1'b0}); // LHU
      tbl.push_back('{1'b1, 12'h011, 32'h123456AA, 3'b000, 32'h0000_0000, 1'b0}); // SB
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b010, 32'hDEADAAEF, 1'b0}); // LW
      tbl.push_back('{1'b1, 12'h012, 32'h00001234, 3'b001, 32'h0000_0000, 1'b0}); // SH
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b010, 32'h1234AAEF, 1'b0}); // LW
      tbl.push_back('{1'b0, 12'h012, 32'h0,        3'b010, 32'h0000_0000, 1'b1}); // LW misaligned
      tbl.push_back('{1'b1, 12'h011, 32'hFFFFFFFF, 3'b010, 32'h0000_0000, 1'b1}); // SW misaligned
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b010, 32'h1234AAEF, 1'b0}); // LW unchanged
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b011, 32'h0000_0000, 1'b1}); // load f3=011
      tbl.push_back('{1'b1, 12'h011, 32'h0000FFFF, 3'b001, 32'h0000_0000, 1'b1}); // SH misaligned
      tbl.push_back('{1'b1, 12'h010, 32'h00000000, 3'b100, 32'h0000_0000, 1'b1}); // store f3=100
      tbl.push_back('{1'b0, 12'h011, 32'h0,        3'b101, 32'h0000_0000, 1'b1}); // LHU misaligned
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b010, 32'h1234AAEF, 1'b0}); // LW unchanged
      tbl.push_back('{1'b0, 12'h011, 32'h0,        3'b000, 32'hFFFFFFAA, 1'b0}); // LB
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b100, 32'h000000EF, 1'b0}); // LBU
      tbl.push_back('{1'b0, 12'h010, 32'h0,        3'b110, 32'h0000_0000, 1'b1}); // load f3=110

      rst_n      = '0;
      req_valid  = '0;
      req_write  = '0;
      req_addr   = '0;
      req_wdata  = '0;
      req_funct3 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_ready", k, 32'(req_ready[k]), 32'd1);
         check("rst_resp_valid", k, 32'(resp_valid[k]), 32'd0);
         check("rst_rdata", k, resp_rdata[k], 32'd0);
         check("rst_err", k, 32'(resp_err[k]), 32'd0);
      end
      rst_n = 3'b111;

      for (int i = 0; i < tbl.size(); i++)
         run_req(0, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].f3, tbl[i].exp_d, tbl[i].exp_e, i);

      // Latency sweep: 3 back-to-back loads on latency 1 and latency 4.
      for (int k = 1; k < 3; k++) begin
         run_req(k, 1'b1, 12'h000, 32'h11223344, 3'b010, 32'h0,        1'b0, 100 + k);
         run_req(k, 1'b0, 12'h000, 32'h0,        3'b010, 32'h11223344, 1'b0, 110 + k);
         run_req(k, 1'b0, 12'h002, 32'h0,        3'b101, 32'h00001122, 1'b0, 120 + k);
         run_req(k, 1'b0, 12'h000, 32'h0,        3'b000, 32'h00000044, 1'b0, 130 + k);
      end

      // Reset two cycles into a latency-4 store: request dropped, RAM untouched.
      run_req(2, 1'b1, 12'h020, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 200);
      run_req(2, 1'b0, 12'h020, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 201);
      @(negedge clk);
      req_valid[2]  = 1'b1;
      req_write[2]  = 1'b1;
      req_addr[2]   = 12'h020;
      req_wdata[2]  = 32'h00000055;
      req_funct3[2] = 3'b010;
      saw_resp = 1'b0;
      repeat (2) begin
         @(negedge clk);
         saw_resp |= resp_valid[2];
      end
      rst_n[2]     = 1'b0;
      req_valid[2] = 1'b0;
      @(negedge clk);
      check("abort_ready", 202, 32'(req_ready[2]), 32'd1);
      check("abort_resp_valid", 202, 32'(resp_valid[2]), 32'd0);
      check("abort_rdata", 202, resp_rdata[2], 32'd0);
      check("abort_err", 202, 32'(resp_err[2]), 32'd0);
      check("abort_stall", 202, 32'(stall[2]), 32'd0);
      rst_n[2] = 1'b1;
      repeat (8) begin
         @(negedge clk);
         saw_resp |= resp_valid[2];
      end
      check("abort_no_resp", 202, 32'(saw_resp), 32'd0);
      run_req(2, 1'b0, 12'h020, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 203);

      // Reset exactly on the edge that would enter RESP (latency 2): store not committed.
      run_req(0, 1'b1, 12'h030, 32'h01020304, 3'b010, 32'h0, 1'b0, 300);
      @(negedge clk);
      req_valid[0]  = 1'b1;
      req_write[0]  = 1'b1;
      req_addr[0]   = 12'h030;
      req_wdata[0]  = 32'hFFFFFFFF;
      req_funct3[0] = 3'b010;
      @(negedge clk);
      rst_n[0]     = 1'b0;
      req_valid[0] = 1'b0;
      saw_resp     = 1'b0;
      @(negedge clk);
      saw_resp |= resp_valid[0];
      rst_n[0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         saw_resp |= resp_valid[0];
      end
      check("edge_abort_no_resp", 301, 32'(saw_resp), 32'd0);
      run_req(0, 1'b0, 12'h030, 32'h0, 3'b010, 32'h01020304, 1'b0, 302);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the pipelined RISC-V datapath's memory stage. It accepts load/store requests issued from the EX/MEM side and models a multi-cycle data RAM. It returns load data with RISC-V byte/half/word extension, and drives the pipeline `stall` line while a request is outstanding.

## Interface
- `data_width`, 32, data word width in bits.
- `address_width`, 12, byte address width; RAM holds 2^(address_width-2) words.
- `latency`, 2, cycles from request acceptance to response; legal range 1..15.

- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge.
- `req_valid`  in  1  request present; held with its fields until the response cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  address_width  byte address.
- `req_wdata`  in  data_width  store data; low byte/half is used for SB/SH.
- `req_funct3`  in  3  RISC-V funct3 size/sign code.
- `req_ready`  out  1  high only in IDLE.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  data_width  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal access; valid with `resp_valid`.
- `stall`  out  1  combinational: `req_valid & ~resp_valid`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - WAIT: count down.
  - RESP: `resp_valid`=1 for exactly one cycle.
- IDLE with `req_valid`=1 latches `req_*` into internal registers. The counter loads `latency-1`. Next state is WAIT, or RESP directly if `latency`=1.
- WAIT decrements the counter each cycle. It moves to RESP on the edge where the counter equals 1.
- RESP always returns to IDLE. `req_valid` during RESP is ignored.
- Little-endian byte lanes: word index is `addr[address_width-1:2]`, byte lane is `addr[1:0]`.
- Load funct3 codes:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
- Store funct3 codes: 000 SB, 001 SH, 010 SW. Only the addressed byte lanes are written.
- Error conditions, flagged by `resp_err`=1:
  - Half access with `addr[0]`≠0.
  - Word access with `addr[1:0]`≠0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 other than 000, 001 or 010.
- On error the RAM is untouched, `resp_rdata`=0, and the response still arrives after `latency` cycles.
- RAM is read, and stores are committed, on the edge entering RESP. `resp_rdata` is registered on that same edge.
- `resp_rdata` holds its value until the next response. `resp_err` is 0 outside RESP.
- If `req_valid` drops while in WAIT, that is a protocol violation. The latched request completes anyway.

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- RAM contents are not affected by reset.
- A request accepted at the end of cycle N gets its response in cycle N+`latency`.
- Throughput is one request per `latency`+1 cycles.
- `stall` is high in cycles N..N+`latency`-1, and low in the response cycle so the pipeline advances.
- Back-to-back requests: the next request is seen in the IDLE cycle after RESP and is accepted at the end of that cycle.
- Reset asserted in IDLE, WAIT or RESP: on that edge the pending request is dropped and the FSM enters IDLE.
  - If reset is asserted on the edge that would enter RESP, the store is not committed.
  - No `resp_valid` is produced for the dropped request.
- Reset has priority over all other events on the same edge.

## Test plan
- Word store then load, `latency`=2: SW `0x010` with `0xDEADBEEF`, then LW `0x010`.
  - Each response arrives exactly 2 cycles after acceptance.
  - The LW returns `resp_rdata`=`0xDEADBEEF` with `resp_err`=0.
  - `stall` is high for 2 cycles per request.
- Byte and half extension on that word:
  - LB `0x013` returns `0xFFFFFFDE`.
  - LBU `0x013` returns `0x000000DE`.
  - LH `0x012` returns `0xFFFFDEAD`.
  - LHU `0x010` returns `0x0000BEEF`.
- Partial store: SB `0x011` with `req_wdata`=`0x123456AA`, then LW `0x010` returns `0xDEADAAEF`. SH `0x012` with `0x00001234`, then LW returns `0x1234AAEF`.
- Errors:
  - LW `0x012` gives `resp_err`=1 and `resp_rdata`=0.
  - SW `0x011` gives `resp_err`=1; a later LW `0x010` is unchanged.
  - Load funct3=011 gives `resp_err`=1.
- Latency sweep for `latency`=1 and 4: the response lands on cycle N+`latency`. Across 3 back-to-back loads, `req_ready` and `resp_valid` are never both high.
- Reset mid-operation: with `latency`=4, start SW `0x020` with `0x55`, then pull `reset` low 2 cycles after acceptance.
  - No `resp_valid` appears.
  - All outputs return to their reset values.
  - A subsequent LW `0x020` returns the pre-store contents.
